// File: rtl/cursor_paleta_dp.sv
// Palette-cursor datapath: cursor coordinates, side counter C, white/black
// blink timers and a one-pixel-per-cycle frame-buffer write port.
module cursor_paleta_dp #(
  parameter int COORD_W  = 6,
  parameter int X0       = 2,
  parameter int Y0       = 58,
  parameter int PAL_STEP = 8,
  parameter int BLINK_W  = 24,
  parameter int T_WHITE  = 6000000,
  parameter int T_BLACK  = 6000000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [2:0]             pal_sel,
  input  logic                   out_rst,
  input  logic                   rst_cont,
  input  logic                   plus,
  input  logic                   sum,
  input  logic                   Change_X,
  input  logic                   Change_Y,
  input  logic                   paint,
  input  logic [7:0]             px_data,
  input  logic                   Contar_Blanco_S,
  input  logic                   Contar_Negro_S,
  output logic [2:0]             C,
  output logic                   CB,
  output logic                   CN,
  output logic                   wr_en,
  output logic [2*COORD_W-1:0]   wr_addr,
  output logic [7:0]             wr_data
);

  localparam logic [COORD_W-1:0] X_ORG  = COORD_W'(X0);
  localparam logic [COORD_W-1:0] Y_ORG  = COORD_W'(Y0);
  localparam logic [BLINK_W-1:0] W_LAST = BLINK_W'(T_WHITE - 1);
  localparam logic [BLINK_W-1:0] B_LAST = BLINK_W'(T_BLACK - 1);

  typedef enum logic {COUNT = 1'b0, DONE = 1'b1} blink_t;

  logic [COORD_W-1:0] x, y, x_load;
  logic [31:0]        load_full;
  logic [BLINK_W-1:0] wcnt, wcnt_next, bcnt, bcnt_next;
  blink_t             w_state, w_next, b_state, b_next;

  // Origin of the selected swatch's square; wraps to the coordinate width.
  always_comb begin
    load_full = 32'(X0) + 32'(pal_sel) * 32'(PAL_STEP);
    x_load    = load_full[COORD_W-1:0];
  end

  // Cursor coordinates; a load wins over any move in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x <= X_ORG;
      y <= Y_ORG;
    end else if (out_rst) begin
      x <= x_load;
      y <= Y_ORG;
    end else begin
      if (Change_X) x <= sum ? x + {{(COORD_W-1){1'b0}}, 1'b1} : x - {{(COORD_W-1){1'b0}}, 1'b1};
      if (Change_Y) y <= sum ? y + {{(COORD_W-1){1'b0}}, 1'b1} : y - {{(COORD_W-1){1'b0}}, 1'b1};
    end
  end

  // Side counter, saturating at 7.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      C <= 3'd0;
    end else if (out_rst || rst_cont) begin
      C <= 3'd0;
    end else if (plus && (C != 3'd7)) begin
      C <= C + 3'd1;
    end
  end

  // Write port: captures pre-move coordinates, address/data hold when idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= 8'd0;
    end else begin
      wr_en <= paint;
      if (paint) begin
        wr_addr <= {y, x};
        wr_data <= px_data;
      end
    end
  end

  // Blink phase state and counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_state <= COUNT;
      b_state <= COUNT;
      wcnt    <= '0;
      bcnt    <= '0;
    end else begin
      w_state <= w_next;
      b_state <= b_next;
      wcnt    <= wcnt_next;
      bcnt    <= bcnt_next;
    end
  end

  // White phase next state: counts enabled cycles until the terminal value.
  always_comb begin
    w_next    = w_state;
    wcnt_next = wcnt;
    if (out_rst) begin
      w_next    = COUNT;
      wcnt_next = '0;
    end else begin
      case (w_state)
        COUNT: begin
          if (Contar_Blanco_S) begin
            if (wcnt == W_LAST) begin
              w_next    = DONE;
              wcnt_next = '0;
            end else begin
              wcnt_next = wcnt + {{(BLINK_W-1){1'b0}}, 1'b1};
            end
          end else begin
            wcnt_next = wcnt;
          end
        end
        DONE:    w_next = DONE;
        default: w_next = COUNT;
      endcase
    end
  end

  // Black phase next state, same scheme as white.
  always_comb begin
    b_next    = b_state;
    bcnt_next = bcnt;
    if (out_rst) begin
      b_next    = COUNT;
      bcnt_next = '0;
    end else begin
      case (b_state)
        COUNT: begin
          if (Contar_Negro_S) begin
            if (bcnt == B_LAST) begin
              b_next    = DONE;
              bcnt_next = '0;
            end else begin
              bcnt_next = bcnt + {{(BLINK_W-1){1'b0}}, 1'b1};
            end
          end else begin
            bcnt_next = bcnt;
          end
        end
        DONE:    b_next = DONE;
        default: b_next = COUNT;
      endcase
    end
  end

  assign CB = (w_state == DONE);
  assign CN = (b_state == DONE);

endmodule

// File: tb/tb_cursor_paleta_dp.sv
// Randomised/directed bench for cursor_paleta_dp with a queue scoreboard for
// frame-buffer writes and a cycle-level model for C, CB and CN.
module tb_cursor_paleta_dp;
  localparam int TW = 5;
  localparam int TB = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  pal_sel = 3'd0;
  logic        out_rst = 1'b0, rst_cont = 1'b0, plus = 1'b0, sum = 1'b0;
  logic        Change_X = 1'b0, Change_Y = 1'b0, paint = 1'b0;
  logic [7:0]  px_data = 8'd0;
  logic        Contar_Blanco_S = 1'b0, Contar_Negro_S = 1'b0;
  logic [2:0]  C;
  logic        CB, CN, wr_en;
  logic [11:0] wr_addr;
  logic [7:0]  wr_data;

  cursor_paleta_dp #(.T_WHITE(TW), .T_BLACK(TB)) dut (
    .clk(clk), .rst(rst), .pal_sel(pal_sel), .out_rst(out_rst),
    .rst_cont(rst_cont), .plus(plus), .sum(sum), .Change_X(Change_X),
    .Change_Y(Change_Y), .paint(paint), .px_data(px_data),
    .Contar_Blanco_S(Contar_Blanco_S), .Contar_Negro_S(Contar_Negro_S),
    .C(C), .CB(CB), .CN(CN), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [19:0] sb[$];

  int x_m, y_m, c_m, wc_m, bc_m;
  bit cb_m, cn_m;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    x_m = 2; y_m = 58; c_m = 0; wc_m = 0; bc_m = 0; cb_m = 0; cn_m = 0;
  endtask

  // Monitor: every presented write is popped and compared.
  always @(negedge clk) begin
    if (rst && wr_en) begin
      if (sb.size() == 0) begin
        chk("unexpected_write", 1, 0);
      end else begin
        logic [19:0] e;
        e = sb.pop_front();
        chk("wr_addr", int'(wr_addr), int'(e[19:8]));
        chk("wr_data", int'(wr_data), int'(e[7:0]));
      end
    end
  end

  task automatic step(input bit o, input bit rc, input bit pl, input bit sm,
                      input bit cx, input bit cy, input bit pt,
                      input logic [7:0] d, input bit wb, input bit wn);
    out_rst = o; rst_cont = rc; plus = pl; sum = sm; Change_X = cx;
    Change_Y = cy; paint = pt; px_data = d; Contar_Blanco_S = wb; Contar_Negro_S = wn;
    @(posedge clk);
    if (pt) sb.push_back({12'(y_m * 64 + x_m), d});
    if (o) begin
      x_m = (2 + int'(pal_sel) * 8) % 64;
      y_m = 58;
    end else begin
      if (cx) x_m = sm ? (x_m + 1) % 64 : (x_m + 63) % 64;
      if (cy) y_m = sm ? (y_m + 1) % 64 : (y_m + 63) % 64;
    end
    if (o || rc) c_m = 0;
    else if (pl) c_m = (c_m + 1 > 7) ? 7 : c_m + 1;
    if (o) begin
      cb_m = 0; cn_m = 0; wc_m = 0; bc_m = 0;
    end else begin
      if (wb && !cb_m) begin
        wc_m++;
        if (wc_m == TW) begin cb_m = 1; wc_m = 0; end
      end
      if (wn && !cn_m) begin
        bc_m++;
        if (bc_m == TB) begin cn_m = 1; bc_m = 0; end
      end
    end
    #1;
    chk("C", int'(C), c_m);
    chk("CB", int'(CB), int'(cb_m));
    chk("CN", int'(CN), int'(cn_m));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 8'd0, 0, 0);
  endtask

  initial begin
    model_reset();
    #1;
    chk("rst_C", int'(C), 0);
    chk("rst_CB", int'(CB), 0);
    chk("rst_CN", int'(CN), 0);
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_wr_addr", int'(wr_addr), 0);
    chk("rst_wr_data", int'(wr_data), 0);
    #2 rst = 1'b1;

    // Load swatch 3, then paint along the top edge.
    pal_sel = 3'd3;
    step(1, 0, 0, 0, 0, 0, 0, 8'd0, 0, 0);
    chk("load_wr_en", int'(wr_en), 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 1, 1, 0, 1, 8'(8'hA0 + i), 0, 0);
      step(0, 0, 1, 0, 0, 0, 0, 8'd0, 0, 0);
    end
    chk("C_after_edge", int'(C), 4);
    step(0, 0, 0, 0, 0, 0, 1, 8'h55, 0, 0);   // expect {58,30}
    chk("x_after_edge", x_m, 30);

    // Wrap in x (63 -> 0) and y (0 -> 63).
    pal_sel = 3'd7;
    step(1, 0, 0, 0, 0, 0, 0, 8'd0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 1, 0, 0, 8'd0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 8'h63, 0, 0);   // {58,63}
    step(0, 0, 0, 1, 1, 0, 1, 8'h64, 0, 0);   // {58,63}, then x -> 0
    for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 0, 1, 0, 8'd0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 1, 8'h65, 0, 0);   // {0,0}, then y -> 63
    step(0, 0, 0, 0, 0, 0, 1, 8'h66, 0, 0);   // {63,0}
    step(1, 0, 0, 0, 0, 0, 1, 8'h67, 0, 0);   // write uses pre-load coords

    // Side counter clear priority and saturation.
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, 0, 0, 8'd0, 0, 0);
    step(0, 1, 1, 0, 0, 0, 0, 8'd0, 0, 0);
    chk("C_rst_cont_wins", int'(C), 0);
    for (int i = 0; i < 9; i++) step(0, 0, 1, 0, 0, 0, 0, 8'd0, 0, 0);
    chk("C_saturated", int'(C), 7);

    // Blink flags: white, then black, pause behaviour, sticky, clear.
    for (int i = 0; i < 7; i++) step(0, 0, 0, 0, 0, 0, 0, 8'd0, 1, 0);
    idle(2);
    chk("CB_sticky", int'(CB), 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 8'd0, 0, 1);
    chk("CN_set", int'(CN), 1);
    step(1, 0, 0, 0, 0, 0, 0, 8'd0, 0, 0);
    chk("CB_clear", int'(CB), 0);
    chk("CN_clear", int'(CN), 0);
    step(0, 0, 0, 0, 0, 0, 0, 8'd0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 8'd0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 8'd0, 1, 1);
    step(0, 0, 0, 0, 0, 0, 0, 8'd0, 0, 1);   // CN sets here after pause

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      pal_sel = 3'($urandom_range(0, 7));
      step($urandom_range(0, 19) == 0, $urandom_range(0, 9) == 0, 1'($urandom),
           1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom),
           $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
    end

    // Asynchronous reset in the middle of a paint burst.
    for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 1, 0, 1, 8'(8'hC0 + i), 1, 1);
    #1 rst = 1'b0;
    #1;
    chk("async_wr_en", int'(wr_en), 0);
    chk("async_wr_addr", int'(wr_addr), 0);
    chk("async_wr_data", int'(wr_data), 0);
    chk("async_C", int'(C), 0);
    chk("async_CB", int'(CB), 0);
    chk("async_CN", int'(CN), 0);
    sb.delete();
    model_reset();
    paint = 1'b0; plus = 1'b0; Change_X = 1'b0;
    Contar_Blanco_S = 1'b0; Contar_Negro_S = 1'b0;
    @(posedge clk);
    #3 rst = 1'b1;
    idle(3);
    step(0, 0, 0, 0, 0, 0, 1, 8'h5A, 0, 0);   // {58,2} after reset
    idle(2);
    chk("scoreboard_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
